// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory signals of the load/store unit.
// The unit takes the slave modport; the core/memory side takes master.
interface load_store_unit_if #(
    parameter int AW = 6
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of force-aligning them.
module load_store_unit #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            accept_s;
    logic            illegal_s;

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic ill;
        case (f3)
            3'b000, 3'b001, 3'b010: ill = 1'b0;
            3'b100, 3'b101:         ill = we;
            default:                ill = 1'b1;
        endcase
        return ill;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    // Halfwords use offset bit 1 only, words ignore the offset: this is the force-align rule.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (f3[1:0])
            2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign accept_s = bus.req_valid && (state_q == S_IDLE);

    // Request legality check on the live request fields
    always_comb begin
        illegal_s = funct3_illegal(bus.req_we, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        illegal_s = illegal_s | misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        state_d = S_RESP;
                    end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: request latch, RMW merge into the write word, load result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr[AW+1:0];
                        wdata_q  <= bus.req_wdata;
                        err_q    <= illegal_s;
                        if (illegal_s) begin
                            rdata_q <= 32'd0;
                        end
                    end
                end
                S_RD: begin
                    if (we_q) begin
                        wdata_q <= merge(bus.mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
                    end else begin
                        rdata_q <= extract(bus.mem_rdata, funct3_q, addr_q[1:0]);
                    end
                end
                S_WR:    rdata_q <= 32'd0;
                default: rdata_q <= rdata_q;
            endcase
        end
    end

    // Output decode; memory strobes are gated by rst so a reset edge never commits a write
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        case (state_q)
            S_IDLE:  bus.req_ready = 1'b1;
            S_RD:    bus.mem_read  = ~rst;
            S_WR:    bus.mem_write = ~rst;
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

    assign bus.mem_addr  = addr_q[AW+1:2];
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios then random traffic
// against a byte-lane arithmetic reference model of the data memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    load_store_unit_if #(.AW(6)) lsu_bus ();

    load_store_unit #(.AW(6), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lsu_bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    assign lsu_bus.mem_rdata = mem[lsu_bus.mem_addr];

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (lsu_bus.mem_write) mem[lsu_bus.mem_addr] <= lsu_bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit e;
        e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (we && (f3 == 3'd4 || f3 == 3'd5)) e = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'd0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
        int sh;
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            sh = int'(a[1:0]) * 8;
            v  = (w >> sh) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            sh = a[1] ? 16 : 0;
            v  = (w >> sh) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [31:0] a);
        int sh;
        logic [31:0] mask;
        if (f3 == 3'd0) begin
            sh = int'(a[1:0]) * 8;
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh = a[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = idx[5:0]; pl_data = val;
        @(posedge clk); #1;
        pl_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag, output logic [31:0] obs_rd);
        int lat = 0;
        int guard = 0;
        bit got = 0, saw_rd = 0, saw_wr = 0, wr_first = 0, overlap = 0;
        logic er = 1'b0;
        bit e;
        int idx;
        int exp_lat;
        logic [31:0] exp_rd;
        logic [2:0] exp_acc;
        obs_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        while (!lsu_bus.req_ready && guard < 10) begin
            guard++;
            @(negedge clk);
        end
        check({tag, "_ready"}, {31'd0, lsu_bus.req_ready}, 32'd1);
        lsu_bus.req_valid = 1'b1; lsu_bus.req_we = we; lsu_bus.req_funct3 = f3;
        lsu_bus.req_addr = a; lsu_bus.req_wdata = wd;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) lsu_bus.req_valid = 1'b0;
            if (lsu_bus.mem_read) saw_rd = 1'b1;
            if (lsu_bus.mem_write) begin
                saw_wr = 1'b1;
                if (!saw_rd) wr_first = 1'b1;
            end
            if (lsu_bus.mem_read && lsu_bus.mem_write) overlap = 1'b1;
            if (lsu_bus.rsp_valid) begin
                got = 1'b1; lat = c; obs_rd = lsu_bus.rsp_rdata; er = lsu_bus.rsp_err;
            end
        end
        e   = exp_err(we, f3, a);
        idx = int'(a[7:2]);
        if (e) begin
            exp_lat = 1; exp_rd = 32'd0; exp_acc = 3'b000;
        end else if (!we) begin
            exp_lat = 2; exp_rd = exp_load(ref_mem[idx], f3, a); exp_acc = 3'b100;
        end else if (f3 == 3'd2) begin
            exp_lat = 2; exp_rd = 32'd0; exp_acc = 3'b011;
        end else begin
            exp_lat = 3; exp_rd = 32'd0; exp_acc = 3'b110;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_err"}, {31'd0, er}, {31'd0, e});
        check({tag, "_rdata"}, obs_rd, exp_rd);
        check({tag, "_access"}, {29'd0, saw_rd, saw_wr, wr_first}, {29'd0, exp_acc});
        check({tag, "_rw_overlap"}, {31'd0, overlap}, 32'd0);
        if (we && !e) ref_mem[idx] = exp_store(ref_mem[idx], wd, f3, a);
    endtask

    initial begin
        logic [31:0] rd;
        int guard;
        rst = 1'b1;
        pl_we = 1'b0; pl_addr = 6'd0; pl_data = 32'd0;
        lsu_bus.req_valid = 1'b0; lsu_bus.req_we = 1'b0; lsu_bus.req_funct3 = 3'd0;
        lsu_bus.req_addr = 32'd0; lsu_bus.req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // Reset state, sampled with rst still asserted
        @(posedge clk); #1;
        check("rst_req_ready", {31'd0, lsu_bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, lsu_bus.rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, lsu_bus.rsp_err}, 32'd0);
        check("rst_rsp_rdata", lsu_bus.rsp_rdata, 32'd0);
        check("rst_mem_rw", {30'd0, lsu_bus.mem_read, lsu_bus.mem_write}, 32'd0);
        check("rst_mem_addr", {26'd0, lsu_bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", lsu_bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(0, 32'd30); preload(1, 32'd25); preload(2, 32'd5);
        run_req(1'b0, 3'b010, 32'h4, 32'd0, "lw_0x4", rd);
        check("lw_0x4_value", rd, 32'd25);

        preload(1, 32'h0000_00F0);
        run_req(1'b0, 3'b000, 32'h4, 32'd0, "lb_0x4", rd);
        check("lb_0x4_value", rd, 32'hFFFF_FFF0);
        run_req(1'b0, 3'b100, 32'h4, 32'd0, "lbu_0x4", rd);
        check("lbu_0x4_value", rd, 32'h0000_00F0);

        run_req(1'b1, 3'b000, 32'h9, 32'h0000_00AB, "sb_0x9", rd);
        check("sb_0x9_word2", mem[2], 32'h0000_AB05);

        run_req(1'b0, 3'b011, 32'h0, 32'd0, "f3_011", rd);
        run_req(1'b1, 3'b100, 32'h0, 32'd0, "sbu_illegal", rd);

        run_req(1'b0, 3'b010, 32'h2, 32'd0, "lw_0x2", rd);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_0x2_value", rd, 32'd0);
`else
        check("lw_0x2_value", rd, 32'd30);
`endif
        run_req(1'b1, 3'b001, 32'h0000_1236, 32'h1234_8001, "sh_high_hi_bits", rd);
        run_req(1'b0, 3'b001, 32'h0000_0036, 32'd0, "lh_signed", rd);
        check("lh_signed_value", rd, 32'hFFFF_8001);

        // Reset during the WR cycle of a sub-word store
        preload(3, 32'h1122_3344);
        @(negedge clk);
        lsu_bus.req_valid = 1'b1; lsu_bus.req_we = 1'b1; lsu_bus.req_funct3 = 3'b000;
        lsu_bus.req_addr = 32'hD; lsu_bus.req_wdata = 32'h0000_00EE;
        @(posedge clk); #1;
        lsu_bus.req_valid = 1'b0;
        guard = 0;
        while (!lsu_bus.mem_write && guard < 8) begin
            guard++;
            @(posedge clk); #1;
        end
        check("rstwr_reached_wr", {31'd0, lsu_bus.mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstwr_strobe_gated", {31'd0, lsu_bus.mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstwr_word_kept", mem[3], 32'h1122_3344);
        check("rstwr_ready", {31'd0, lsu_bus.req_ready}, 32'd1);
        check("rstwr_no_write", {30'd0, lsu_bus.mem_read, lsu_bus.mem_write}, 32'd0);
        check("rstwr_no_rsp", {31'd0, lsu_bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rstwr_still_idle", {31'd0, lsu_bus.req_ready}, 32'd1);

        for (int n = 0; n < 60; n++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $sformatf("rnd%0d", n), rd);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
